// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared types and constants for the RV32 ID/EX pipeline register.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

  localparam int RV_XLEN   = 32;
  localparam int RV_REG_AW = 5;

  localparam logic [RV_REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  typedef struct packed {
    logic [RV_XLEN-1:0]   rs1_data;
    logic [RV_XLEN-1:0]   rs2_data;
    logic [RV_XLEN-1:0]   imm;
    logic [RV_REG_AW-1:0] rs1_addr;
    logic [RV_REG_AW-1:0] rs2_addr;
    logic [RV_REG_AW-1:0] rd_addr;
    alu_op_e              alu_ctrl;
    logic                 alu_src;
    logic                 reg_write;
  } id_ex_t;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module   : fwd_mux
// Purpose  : Operand bypass select; EX/MEM beats MEM/WB, x0 never forwarded.
// Revision : 1.0
// ============================================================================
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_val,
  input  logic              i_mem_en,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic [WIDTH-1:0]  i_mem_data,
  input  logic              i_wb_en,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [WIDTH-1:0]  i_wb_data,
  output logic [WIDTH-1:0]  o_val
);

  logic w_nonzero;
  logic w_hit_mem;
  logic w_hit_wb;

  assign w_nonzero = (i_addr != REG_AW'(REG_ZERO));
  assign w_hit_mem = w_nonzero && i_mem_en && (i_mem_rd == i_addr);
  assign w_hit_wb  = w_nonzero && i_wb_en  && (i_wb_rd  == i_addr);

  always_comb begin
    o_val = i_val;
    if (w_hit_mem) begin
      o_val = i_mem_data;
    end else if (w_hit_wb) begin
      o_val = i_wb_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : Decode-to-execute register with operand forwarding, stall and flush.
// Revision : 1.0
// ============================================================================
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_rs1_data,
  input  logic [WIDTH-1:0]  in_rs2_data,
  input  logic [WIDTH-1:0]  in_imm,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [2:0]        in_alu_ctrl,
  input  logic              in_alu_src,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              fwd_mem_en,
  input  logic [REG_AW-1:0] fwd_mem_rd,
  input  logic [WIDTH-1:0]  fwd_mem_data,
  input  logic              fwd_wb_en,
  input  logic [REG_AW-1:0] fwd_wb_rd,
  input  logic [WIDTH-1:0]  fwd_wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  d0,
  output logic [WIDTH-1:0]  d1,
  output logic [2:0]        ALUctrl,
  output logic [WIDTH-1:0]  store_data,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_reg_write
);

  stage_state_e r_state;
  stage_state_e w_state_nxt;
  id_ex_t       r_hold;

  logic              w_fire_in;
  logic              w_fire_out;
  logic              w_capture;
  logic [REG_AW-1:0] w_sel_rs1_addr;
  logic [REG_AW-1:0] w_sel_rs2_addr;
  logic [WIDTH-1:0]  w_sel_rs1_val;
  logic [WIDTH-1:0]  w_sel_rs2_val;
  logic [WIDTH-1:0]  w_upd_rs1;
  logic [WIDTH-1:0]  w_upd_rs2;
  logic [WIDTH-1:0]  w_out_rs1;
  logic [WIDTH-1:0]  w_out_rs2;

  assign in_ready   = (r_state == ST_EMPTY) || out_ready;
  assign out_valid  = (r_state == ST_FULL);
  assign w_fire_in  = in_valid && in_ready;
  assign w_fire_out = out_valid && out_ready;
  assign w_capture  = w_fire_in && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_fire_in)                w_state_nxt = ST_FULL;
        ST_FULL:  if (w_fire_out && !w_fire_in) w_state_nxt = ST_EMPTY;
        default:                                w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // One mux pair serves both capture (incoming operands) and refresh (held operands).
  assign w_sel_rs1_addr = w_fire_in ? in_rs1_addr : r_hold.rs1_addr;
  assign w_sel_rs2_addr = w_fire_in ? in_rs2_addr : r_hold.rs2_addr;
  assign w_sel_rs1_val  = w_fire_in ? in_rs1_data : r_hold.rs1_data;
  assign w_sel_rs2_val  = w_fire_in ? in_rs2_data : r_hold.rs2_data;

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_upd_rs1 (
    .i_addr(w_sel_rs1_addr), .i_val(w_sel_rs1_val),
    .i_mem_en(fwd_mem_en), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_en(fwd_wb_en), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_val(w_upd_rs1)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_upd_rs2 (
    .i_addr(w_sel_rs2_addr), .i_val(w_sel_rs2_val),
    .i_mem_en(fwd_mem_en), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_en(fwd_wb_en), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_val(w_upd_rs2)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_out_rs1 (
    .i_addr(r_hold.rs1_addr), .i_val(r_hold.rs1_data),
    .i_mem_en(fwd_mem_en), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_en(fwd_wb_en), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_val(w_out_rs1)
  );

  fwd_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_out_rs2 (
    .i_addr(r_hold.rs2_addr), .i_val(r_hold.rs2_data),
    .i_mem_en(fwd_mem_en), .i_mem_rd(fwd_mem_rd), .i_mem_data(fwd_mem_data),
    .i_wb_en(fwd_wb_en), .i_wb_rd(fwd_wb_rd), .i_wb_data(fwd_wb_data),
    .o_val(w_out_rs2)
  );

  // Refreshing while held keeps a writeback that retires during a stall from being lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (w_capture) begin
      r_hold.rs1_data  <= w_upd_rs1;
      r_hold.rs2_data  <= w_upd_rs2;
      r_hold.imm       <= in_imm;
      r_hold.rs1_addr  <= in_rs1_addr;
      r_hold.rs2_addr  <= in_rs2_addr;
      r_hold.rd_addr   <= in_rd_addr;
      r_hold.alu_ctrl  <= alu_op_e'(in_alu_ctrl);
      r_hold.alu_src   <= in_alu_src;
      r_hold.reg_write <= in_reg_write;
    end else if (r_state == ST_FULL) begin
      r_hold.rs1_data  <= w_upd_rs1;
      r_hold.rs2_data  <= w_upd_rs2;
    end
  end

  assign d0            = w_out_rs1;
  assign store_data    = w_out_rs2;
  assign d1            = r_hold.alu_src ? r_hold.imm : w_out_rs2;
  assign ALUctrl       = r_hold.alu_ctrl;
  assign out_rd_addr   = r_hold.rd_addr;
  assign out_reg_write = r_hold.reg_write && out_valid;

endmodule
`default_nettype wire
